cmd_frame_rx: RTL

//  Command-frame assembler between uart_rx and the SRAM-driver control FSM.
//  - Collects 6-byte frames from the serial byte stream: opcode, 32-bit argument (MSB first), 0x00 terminator.
//  - Validates each frame and presents {cmd, arg} to the control FSM on a valid/ready handshake.
//  - Discards malformed frames and resynchronises on the next legal opcode.

---
 rtl/cmd_frame_rx_pkg.sv | 23 ++
 rtl/cmd_frame_rx_gap_timer.sv | 32 +++
 rtl/cmd_frame_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cmd_frame_rx_pkg.sv
// Shared definitions for the command-frame path: opcode values, frame
// layout constants and the receiver FSM state encoding. Imported by
// cmd_frame_rx and by the benches so both agree on the byte format.
package cmd_frame_rx_pkg;

  localparam logic [7:0] ADDR      = 8'd1;
  localparam logic [7:0] LOAD      = 8'd2;
  localparam logic [7:0] WRITE     = 8'd3;
  localparam logic [7:0] READ      = 8'd4;
  localparam logic [7:0] READ_REQ  = 8'd5;
  localparam logic [7:0] COUNT     = 8'd6;
  localparam logic [7:0] CONST     = 8'd7;

  localparam int         FRAME_LEN = 6;
  localparam logic [7:0] TERM_BYTE = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_TERM = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_frame_rx_gap_timer.sv
// gap_timer: counts clock cycles between bytes of a frame.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - restart the count at zero
//   enable      - count while high
//   expired     - high while the count equals TIMEOUT_CYCLES (count holds there)
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: assembles 6-byte command frames (opcode, 32-bit argument
// MSB first, 0x00 terminator) from the uart_rx byte stream and hands
// {cmd, arg} to the control FSM through a one-deep valid/ready slot.
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte gap timeout).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx_data, rx_valid   - byte stream from uart_rx (one-cycle strobe)
//   cmd_valid, cmd_ready- output handshake; slot held until accepted
//   cmd, arg            - decoded opcode and argument
//   frame_err           - one-cycle pulse: bad opcode/terminator/timeout
//   overrun             - one-cycle pulse: good frame dropped, slot full
module cmd_frame_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter logic [7:0] MAX_CMD        = 8'd7,
  parameter int         TIMEOUT_CYCLES = 5000,
  parameter int         TIMEOUT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd,
  output logic [31:0] arg,
  output logic        frame_err,
  output logic        overrun
);

  state_t      state_q, state_d;
  logic [1:0]  cnt;
  logic [7:0]  shadow_cmd;
  logic [31:0] shadow_arg;
  logic        timeout_exp;
  logic        opcode_ok;
  logic        frame_done;
  logic        err_d;
  logic        overrun_d;
  logic        slot_load;

  assign opcode_ok = (rx_data != 8'd0) && (rx_data <= MAX_CMD);

`ifdef CMD_TIMEOUT_EN
  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || (state_q == S_IDLE)),
    .enable (state_q != S_IDLE),
    .expired(timeout_exp)
  );
`else
  // No timer: expiry is constant false; the expression only keeps the
  // timer parameters referenced so both builds share one interface.
  assign timeout_exp = (TIMEOUT_CYCLES < 0) && (TIMEOUT_W < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a byte arriving in the expiry cycle takes priority
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        S_IDLE:  if (opcode_ok) state_d = S_ARG;
        S_ARG:   if (cnt == 2'd3) state_d = S_TERM;
        S_TERM:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_exp && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Output decode: frame completion, error and overrun conditions
  always_comb begin
    frame_done = 1'b0;
    err_d      = 1'b0;
    overrun_d  = 1'b0;
    slot_load  = 1'b0;
    if (rx_valid) begin
      if (state_q == S_IDLE && !opcode_ok)                        err_d = 1'b1;
      if (state_q == S_TERM && rx_data != TERM_BYTE)              err_d = 1'b1;
      if (state_q == S_TERM && rx_data == TERM_BYTE)              frame_done = 1'b1;
    end else if (timeout_exp && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
    // Same-cycle accept frees the slot, so the new frame may replace it
    slot_load = frame_done && (!cmd_valid || cmd_ready);
    overrun_d = frame_done && cmd_valid && !cmd_ready;
  end

  // Shadow frame capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (rx_valid) begin
      if (state_q == S_IDLE) begin
        cnt <= 2'd0;
        if (opcode_ok) shadow_cmd <= rx_data;
      end else if (state_q == S_ARG) begin
        cnt        <= cnt + 2'd1;
        shadow_arg <= {shadow_arg[23:0], rx_data};
      end
    end
  end

  // Output slot and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd       <= 8'd0;
      arg       <= 32'd0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= err_d;
      overrun   <= overrun_d;
      if (slot_load) begin
        cmd_valid <= 1'b1;
        cmd       <= shadow_cmd;
        arg       <= shadow_arg;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
